reservation_station: RTL and testbench

- Receives non-load/store, non-LUI/JAL/AUIPC instructions from reorder_buffer: OP-IMM, OP, BRANCH, JALR.
- Captures source operands from the register file, or waits for them on the ROB commit broadcast (CDB).
- Issues one ready instruction per cycle to the ALU, tagged with its ROB rename. The ALU result returns to the ROB via alu*_finish/alu*_dest/alu*_out.

---
 rtl/reservation_station.sv | 187 ++++++++++++++++++
 tb/tb_reservation_station.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: holds dispatched ALU-class instructions (OP, OP-IMM,
// BRANCH, JALR) until both operands are known, then issues the lowest-index
// ready entry to the ALU, one per cycle, tagged with its ROB rename.
module reservation_station #(
   parameter int unsigned RS_SIZE   = 8,
   parameter int unsigned ROB_TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 new_ins_flag,
   input  logic [31:0]          new_ins,
   input  logic [31:0]          new_ins_pc,
   input  logic [ROB_TAG_W-1:0] rename,
   output logic                 rs_full,
   output logic [4:0]           rf_rs1_idx,
   output logic [4:0]           rf_rs2_idx,
   input  logic                 rf_rs1_busy,
   input  logic [ROB_TAG_W-1:0] rf_rs1_tag,
   input  logic [31:0]          rf_rs1_val,
   input  logic                 rf_rs2_busy,
   input  logic [ROB_TAG_W-1:0] rf_rs2_tag,
   input  logic [31:0]          rf_rs2_val,
   input  logic                 commit_flag,
   input  logic [ROB_TAG_W-1:0] commit_rename,
   input  logic [31:0]          commit_value,
   output logic                 alu_valid,
   output logic [31:0]          alu_ins,
   output logic [31:0]          alu_vj,
   output logic [31:0]          alu_vk,
   output logic [31:0]          alu_imm,
   output logic [31:0]          alu_pc,
   output logic [ROB_TAG_W-1:0] alu_dest
);

   localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic [31:0]          ins;
      logic [31:0]          pc;
      logic [31:0]          imm;
      logic [31:0]          vj;
      logic [31:0]          vk;
      logic [ROB_TAG_W-1:0] dest;
      logic [ROB_TAG_W-1:0] qj;
      logic [ROB_TAG_W-1:0] qk;
      logic                 rj;
      logic                 rk;
   } entry_t;

   logic [RS_SIZE-1:0]   busy;
   entry_t [RS_SIZE-1:0] ent;

   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] issue_idx;
   logic             issue_found;
   logic             dispatch_ok;
   logic [6:0]       opcode;
   logic             uses_rs2;
   entry_t           new_ent;

   assign rs_full     = &busy;
   assign rf_rs1_idx  = new_ins[19:15];
   assign rf_rs2_idx  = new_ins[24:20];
   assign opcode      = new_ins[6:0];
   assign dispatch_ok = new_ins_flag && !rs_full;

   // Priority pick of the lowest free slot and the lowest ready slot from registered state.
   always_comb begin
      free_idx    = '0;
      issue_idx   = '0;
      issue_found = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx = IDX_W'(i);
         end
         if (busy[i] && ent[i].rj && ent[i].rk) begin
            issue_idx   = IDX_W'(i);
            issue_found = 1'b1;
         end
      end
   end

   // Build the entry for a dispatching instruction: immediate decode plus operand capture with CDB bypass.
   always_comb begin
      new_ent      = '0;
      uses_rs2     = 1'b1;
      new_ent.ins  = new_ins;
      new_ent.pc   = new_ins_pc;
      new_ent.dest = rename;

      case (opcode)
         OPC_OP_IMM, OPC_JALR: begin
            uses_rs2    = 1'b0;
            new_ent.imm = {{20{new_ins[31]}}, new_ins[31:20]};
         end
         OPC_BRANCH: begin
            new_ent.imm = {{19{new_ins[31]}}, new_ins[31], new_ins[7],
                           new_ins[30:25], new_ins[11:8], 1'b0};
         end
         default: begin
            new_ent.imm = '0;
         end
      endcase

      if (!rf_rs1_busy) begin
         new_ent.rj = 1'b1;
         new_ent.vj = rf_rs1_val;
      end else if (commit_flag && (commit_rename == rf_rs1_tag)) begin
         new_ent.rj = 1'b1;
         new_ent.vj = commit_value;
      end else begin
         new_ent.qj = rf_rs1_tag;
      end

      if (!uses_rs2) begin
         new_ent.rk = 1'b1;
         new_ent.vk = '0;
      end else if (!rf_rs2_busy) begin
         new_ent.rk = 1'b1;
         new_ent.vk = rf_rs2_val;
      end else if (commit_flag && (commit_rename == rf_rs2_tag)) begin
         new_ent.rk = 1'b1;
         new_ent.vk = commit_value;
      end else begin
         new_ent.qk = rf_rs2_tag;
      end
   end

   // Entry storage: CDB wakeup, release of the issuing slot, and allocation of the free slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         ent  <= '0;
      end else if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && commit_flag) begin
               if (!ent[i].rj && (ent[i].qj == commit_rename)) begin
                  ent[i].vj <= commit_value;
                  ent[i].rj <= 1'b1;
               end
               if (!ent[i].rk && (ent[i].qk == commit_rename)) begin
                  ent[i].vk <= commit_value;
                  ent[i].rk <= 1'b1;
               end
            end
         end
         // The issuing slot is busy and the free slot is not, so they never collide.
         if (issue_found) begin
            busy[issue_idx] <= 1'b0;
         end
         if (dispatch_ok) begin
            busy[free_idx] <= 1'b1;
            ent[free_idx]  <= new_ent;
         end
      end
   end

   // Registered ALU issue port: one-cycle strobe, payload held between issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_valid <= 1'b0;
         alu_ins   <= '0;
         alu_vj    <= '0;
         alu_vk    <= '0;
         alu_imm   <= '0;
         alu_pc    <= '0;
         alu_dest  <= '0;
      end else if (rdy && issue_found) begin
         alu_valid <= 1'b1;
         alu_ins   <= ent[issue_idx].ins;
         alu_vj    <= ent[issue_idx].vj;
         alu_vk    <= ent[issue_idx].vk;
         alu_imm   <= ent[issue_idx].imm;
         alu_pc    <= ent[issue_idx].pc;
         alu_dest  <= ent[issue_idx].dest;
      end else begin
         alu_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus randomized traffic, all
// checked every cycle against a slot-array reference model of the station.
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst, rdy, new_ins_flag;
   logic [31:0] new_ins, new_ins_pc;
   logic [3:0]  rename;
   logic        rs_full;
   logic [4:0]  rf_rs1_idx, rf_rs2_idx;
   logic        rf_rs1_busy, rf_rs2_busy;
   logic [3:0]  rf_rs1_tag, rf_rs2_tag;
   logic [31:0] rf_rs1_val, rf_rs2_val;
   logic        commit_flag;
   logic [3:0]  commit_rename;
   logic [31:0] commit_value;
   logic        alu_valid;
   logic [31:0] alu_ins, alu_vj, alu_vk, alu_imm, alu_pc;
   logic [3:0]  alu_dest;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: slots plus the expected issue-port contents
   bit          m_busy [8];
   bit          m_rj   [8];
   bit          m_rk   [8];
   logic [31:0] m_ins  [8];
   logic [31:0] m_pc   [8];
   logic [31:0] m_imm  [8];
   logic [31:0] m_vj   [8];
   logic [31:0] m_vk   [8];
   logic [3:0]  m_dest [8];
   logic [3:0]  m_qj   [8];
   logic [3:0]  m_qk   [8];
   logic        e_valid;
   logic [31:0] e_ins, e_vj, e_vk, e_imm, e_pc;
   logic [3:0]  e_dest;

   reservation_station #(.RS_SIZE(8), .ROB_TAG_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .new_ins_flag(new_ins_flag), .new_ins(new_ins), .new_ins_pc(new_ins_pc),
      .rename(rename), .rs_full(rs_full),
      .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
      .rf_rs1_busy(rf_rs1_busy), .rf_rs1_tag(rf_rs1_tag), .rf_rs1_val(rf_rs1_val),
      .rf_rs2_busy(rf_rs2_busy), .rf_rs2_tag(rf_rs2_tag), .rf_rs2_val(rf_rs2_val),
      .commit_flag(commit_flag), .commit_rename(commit_rename), .commit_value(commit_value),
      .alu_valid(alu_valid), .alu_ins(alu_ins), .alu_vj(alu_vj), .alu_vk(alu_vk),
      .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_dest(alu_dest)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      i12 = ins[31:20];
      b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      if (ins[6:0] == 7'b0010011 || ins[6:0] == 7'b1100111) return 32'(i12);
      if (ins[6:0] == 7'b1100011) return 32'(b13);
      return 32'd0;
   endfunction

   function automatic bit model_full();
      for (int i = 0; i < 8; i++) if (!m_busy[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven
   task automatic model_step();
      bit found;
      bit full;
      bit two_src;
      int k;
      int fr;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
         e_valid = 1'b0; e_ins = '0; e_vj = '0; e_vk = '0;
         e_imm = '0; e_pc = '0; e_dest = '0;
         return;
      end
      if (!rdy) begin
         e_valid = 1'b0;
         return;
      end
      full = model_full();
      fr = 0;
      for (int i = 7; i >= 0; i--) if (!m_busy[i]) fr = i;
      found = 1'b0;
      k = 0;
      for (int i = 0; i < 8; i++)
         if (!found && m_busy[i] && m_rj[i] && m_rk[i]) begin found = 1'b1; k = i; end
      if (found) begin
         e_valid = 1'b1; e_ins = m_ins[k]; e_vj = m_vj[k]; e_vk = m_vk[k];
         e_imm = m_imm[k]; e_pc = m_pc[k]; e_dest = m_dest[k];
         m_busy[k] = 1'b0;
      end else begin
         e_valid = 1'b0;
      end
      if (commit_flag) begin
         for (int i = 0; i < 8; i++) begin
            if (m_busy[i] && !m_rj[i] && m_qj[i] == commit_rename) begin
               m_rj[i] = 1'b1; m_vj[i] = commit_value;
            end
            if (m_busy[i] && !m_rk[i] && m_qk[i] == commit_rename) begin
               m_rk[i] = 1'b1; m_vk[i] = commit_value;
            end
         end
      end
      if (new_ins_flag) begin
         if (full) begin
            $display("note: dispatch while rs_full is set, instruction dropped (t=%0t)", $time);
         end else begin
            two_src = (new_ins[6:0] == 7'b0110011) || (new_ins[6:0] == 7'b1100011);
            m_busy[fr] = 1'b1;
            m_ins[fr]  = new_ins;
            m_pc[fr]   = new_ins_pc;
            m_imm[fr]  = ref_imm(new_ins);
            m_dest[fr] = rename;
            m_qj[fr]   = rf_rs1_tag;
            m_qk[fr]   = rf_rs2_tag;
            m_rj[fr]   = !rf_rs1_busy || (commit_flag && commit_rename == rf_rs1_tag);
            m_vj[fr]   = !rf_rs1_busy ? rf_rs1_val : commit_value;
            if (!two_src) begin
               m_rk[fr] = 1'b1; m_vk[fr] = 32'd0;
            end else begin
               m_rk[fr] = !rf_rs2_busy || (commit_flag && commit_rename == rf_rs2_tag);
               m_vk[fr] = !rf_rs2_busy ? rf_rs2_val : commit_value;
            end
         end
      end
   endtask

   task automatic check_all();
      check("alu_valid", 32'(alu_valid), 32'(e_valid));
      check("alu_ins",   alu_ins, e_ins);
      check("alu_vj",    alu_vj,  e_vj);
      check("alu_vk",    alu_vk,  e_vk);
      check("alu_imm",   alu_imm, e_imm);
      check("alu_pc",    alu_pc,  e_pc);
      check("alu_dest",  32'(alu_dest), 32'(e_dest));
      check("rs_full",   32'(rs_full), 32'(model_full()));
      check("rf_rs1_idx", 32'(rf_rs1_idx), (new_ins >> 15) & 32'h1f);
      check("rf_rs2_idx", 32'(rf_rs2_idx), (new_ins >> 20) & 32'h1f);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      new_ins_flag = 1'b0; commit_flag = 1'b0;
      rf_rs1_busy = 1'b0; rf_rs2_busy = 1'b0;
   endtask

   task automatic dispatch(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] ren,
                           input logic b1, input logic [3:0] t1, input logic [31:0] v1,
                           input logic b2, input logic [3:0] t2, input logic [31:0] v2);
      new_ins_flag = 1'b1; new_ins = ins; new_ins_pc = pc; rename = ren;
      rf_rs1_busy = b1; rf_rs1_tag = t1; rf_rs1_val = v1;
      rf_rs2_busy = b2; rf_rs2_tag = t2; rf_rs2_val = v2;
   endtask

   task automatic commit(input logic [3:0] tag, input logic [31:0] val);
      commit_flag = 1'b1; commit_rename = tag; commit_value = val;
   endtask

   initial begin
      logic [31:0] r;
      logic [6:0]  ops [4];
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b1100011; ops[3] = 7'b1100111;
      rst = 1'b1; rdy = 1'b1; new_ins = '0; new_ins_pc = '0; rename = '0;
      rf_rs1_tag = '0; rf_rs2_tag = '0; rf_rs1_val = '0; rf_rs2_val = '0;
      commit_rename = '0; commit_value = '0;
      idle();
      tick(); tick();
      check("reset_valid", 32'(alu_valid), 32'd0);
      check("reset_full",  32'(rs_full), 32'd0);
      rst = 1'b0;

      // Reset in the middle of three waiting entries
      for (int i = 0; i < 3; i++) begin
         dispatch(32'h002081B3, 32'h40 + 32'(i * 4), 4'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1);
         tick();
      end
      idle(); rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_full", 32'(rs_full), 32'd0);
      check("midrst_valid", 32'(alu_valid), 32'd0);
      commit(4'd9, 32'h55); tick(); idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst_no_issue", 32'(alu_valid), 32'd0);
      end

      // addi x1,x0,5 with ready operand
      dispatch(32'h00500093, 32'h0, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick(); idle(); tick();
      check("addi_valid", 32'(alu_valid), 32'd1);
      check("addi_dest",  32'(alu_dest), 32'd3);
      check("addi_vj",    alu_vj, 32'd0);
      check("addi_imm",   alu_imm, 32'd5);
      tick();
      check("addi_strobe_end", 32'(alu_valid), 32'd0);

      // add waiting on rs1 tag 5, woken two cycles after dispatch
      dispatch(32'h002081B3, 32'h4, 4'd6, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd7);
      tick(); idle(); tick();
      check("wait_no_issue", 32'(alu_valid), 32'd0);
      commit(4'd5, 32'h10); tick(); idle();
      check("wait_not_on_wake_edge", 32'(alu_valid), 32'd0);
      tick();
      check("wait_valid", 32'(alu_valid), 32'd1);
      check("wait_vj",    alu_vj, 32'h10);
      check("wait_vk",    alu_vk, 32'd7);
      check("wait_dest",  32'(alu_dest), 32'd6);

      // Bypass of a commit in the dispatch cycle
      dispatch(32'h002081B3, 32'h8, 4'd6, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd7);
      commit(4'd5, 32'h22);
      tick(); idle(); tick();
      check("bypass_valid", 32'(alu_valid), 32'd1);
      check("bypass_vj",    alu_vj, 32'h22);

      // Fill all eight slots waiting on tag 9, then a dropped ninth dispatch
      for (int i = 0; i < 8; i++) begin
         dispatch(32'h002081B3, 32'h200 + 32'(i * 4), 4'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(i));
         tick();
      end
      check("full_set", 32'(rs_full), 32'd1);
      dispatch(32'h00500093, 32'h300, 4'd15, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick(); idle(); tick();
      check("full_drop_no_issue", 32'(alu_valid), 32'd0);
      commit(4'd9, 32'h99); tick(); idle();
      for (int i = 0; i < 8; i++) begin
         tick();
         check("order_valid", 32'(alu_valid), 32'd1);
         check("order_dest",  32'(alu_dest), 32'(i));
         check("order_vj",    alu_vj, 32'h99);
         if (i == 0) check("full_clear_after_first", 32'(rs_full), 32'd0);
      end
      tick();
      check("order_drained", 32'(alu_valid), 32'd0);

      // beq x1,x2,+8 at pc 0x100
      dispatch(32'h00208463, 32'h100, 4'd2, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd4);
      tick(); idle(); tick();
      check("beq_valid", 32'(alu_valid), 32'd1);
      check("beq_imm",   alu_imm, 32'd8);
      check("beq_pc",    alu_pc, 32'h100);
      check("beq_vj",    alu_vj, 32'd4);
      check("beq_vk",    alu_vk, 32'd4);

      // rdy gating of a ready entry
      dispatch(32'h00500093, 32'h500, 4'd4, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick(); idle(); rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rdy_low_no_issue", 32'(alu_valid), 32'd0);
      end
      rdy = 1'b1; tick();
      check("rdy_issue", 32'(alu_valid), 32'd1);
      check("rdy_dest",  32'(alu_dest), 32'd4);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         idle();
         rst = ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         if (!model_full() && $urandom_range(0, 1) == 1) begin
            r = $urandom();
            new_ins_flag = 1'b1;
            new_ins = {r[31:7], ops[$urandom_range(0, 3)]};
            new_ins_pc = $urandom();
            rename = 4'($urandom());
            rf_rs1_busy = ($urandom_range(0, 1) == 1) && (new_ins[19:15] != 5'd0);
            rf_rs2_busy = ($urandom_range(0, 1) == 1) && (new_ins[24:20] != 5'd0);
            rf_rs1_tag = 4'($urandom()); rf_rs2_tag = 4'($urandom());
            rf_rs1_val = $urandom(); rf_rs2_val = $urandom();
         end
         if ($urandom_range(0, 9) < 4) commit(4'($urandom()), $urandom());
         tick();
      end
      rst = 1'b0; rdy = 1'b1; idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
